// File: rtl/priv_trap_sequencer.sv
// priv_trap_sequencer: trap entry / mret / wfi sequencing for machine mode.
// Optional feature macro: PRIV_VECTORED_INT_EN (vectored interrupt targets).
module priv_trap_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [8:0]      exc_req,
    input  logic [2:0]      prot_fault,
    input  logic            timer_int,
    input  logic            soft_int,
    input  logic            ext_int,
    input  logic [2:0]      mie_bits,
    input  logic            mstatus_mie,
    input  logic            ret,
    input  logic            wfi,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] badaddr,
    input  logic            pipe_clear,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc_r,
    output logic            insert_pc,
    output logic [XLEN-1:0] priv_pc,
    output logic            intr,
    output logic            trap_we,
    output logic            ret_we,
    output logic [XLEN-1:0] cause_o,
    output logic [XLEN-1:0] epc_o,
    output logic [XLEN-1:0] tval_o,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_REDIRECT = 2'd2,
        S_SLEEP    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_tval;
    logic            r_intr;
    logic            r_ret;
    logic            r_insert_pc;
    logic            r_trap_we;
    logic            r_ret_we;
    logic [XLEN-1:0] r_priv_pc;
    logic            r_busy;

    logic [8:0]      w_exc;
    logic [2:0]      w_pend;
    logic            w_any_exc;
    logic            w_int_take;
    logic [4:0]      w_exc_code;
    logic [4:0]      w_int_code;
    logic [XLEN-1:0] w_cause_sync;
    logic [XLEN-1:0] w_cause_int;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_tgt;
    logic            w_lat_exc;
    logic            w_lat_int;
    logic            w_lat_ret;
    logic            w_enter_redir;

    // PMP/PMA faults fold into the matching access-fault requests
    always_comb begin
        w_exc    = exc_req;
        w_exc[7] = exc_req[7] | prot_fault[2];
        w_exc[5] = exc_req[5] | prot_fault[1];
        w_exc[1] = exc_req[1] | prot_fault[0];
    end

    assign w_pend     = {ext_int, soft_int, timer_int} & mie_bits;
    assign w_any_exc  = |w_exc;
    assign w_int_take = (|w_pend) & mstatus_mie;
    assign w_base     = {mtvec[XLEN-1:2], 2'b00};

    // Fixed-priority pick of the synchronous exception code
    always_comb begin
        w_exc_code = 5'd0;
        if (w_exc[3])      w_exc_code = 5'd3;
        else if (w_exc[1]) w_exc_code = 5'd1;
        else if (w_exc[0]) w_exc_code = 5'd0;
        else if (w_exc[2]) w_exc_code = 5'd2;
        else if (w_exc[8]) w_exc_code = 5'd11;
        else if (w_exc[6]) w_exc_code = 5'd6;
        else if (w_exc[4]) w_exc_code = 5'd4;
        else if (w_exc[7]) w_exc_code = 5'd7;
        else if (w_exc[5]) w_exc_code = 5'd5;
    end

    // Fixed-priority pick of the interrupt code and full cause words
    always_comb begin
        w_int_code = 5'd0;
        if (w_pend[2])      w_int_code = 5'd11;
        else if (w_pend[1]) w_int_code = 5'd3;
        else if (w_pend[0]) w_int_code = 5'd7;
        w_cause_sync             = '0;
        w_cause_sync[4:0]        = w_exc_code;
        w_cause_int              = '0;
        w_cause_int[XLEN-1]      = 1'b1;
        w_cause_int[4:0]         = w_int_code;
    end

    // Redirect target from the latched trap kind
    always_comb begin
        w_tgt = w_base;
        if (r_ret) begin
            w_tgt = mepc_r;
        end
`ifdef PRIV_VECTORED_INT_EN
        else if (r_intr && (mtvec[1:0] == 2'b01)) begin
            w_tgt = w_base + {{(XLEN-7){1'b0}}, r_cause[4:0], 2'b00};
        end
`endif
    end

`ifndef PRIV_VECTORED_INT_EN
    logic w_unused_mode;
    assign w_unused_mode = ^mtvec[1:0];
`endif

    // Next-state and latch-enable decode
    always_comb begin
        w_next    = r_state;
        w_lat_exc = 1'b0;
        w_lat_int = 1'b0;
        w_lat_ret = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_exc) begin
                    w_lat_exc = 1'b1;
                    w_next    = S_DRAIN;
                end else if (w_int_take) begin
                    w_lat_int = 1'b1;
                    w_next    = S_DRAIN;
                end else if (ret) begin
                    w_lat_ret = 1'b1;
                    w_next    = S_DRAIN;
                end else if (wfi) begin
                    w_next    = S_SLEEP;
                end
            end
            S_DRAIN: begin
                if (pipe_clear) w_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                w_next = S_IDLE;
            end
            S_SLEEP: begin
                if (w_any_exc) begin
                    w_lat_exc = 1'b1;
                    w_next    = S_DRAIN;
                end else if (w_int_take) begin
                    w_lat_int = 1'b1;
                    w_next    = S_DRAIN;
                end else if (|w_pend) begin
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_redir = (w_next == S_REDIRECT) && (r_state == S_DRAIN);

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Latched trap record, held from DRAIN entry onward
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cause <= '0;
            r_epc   <= '0;
            r_tval  <= '0;
            r_intr  <= 1'b0;
            r_ret   <= 1'b0;
        end else if (w_lat_exc) begin
            r_cause <= w_cause_sync;
            r_epc   <= epc;
            r_tval  <= badaddr;
            r_intr  <= 1'b0;
            r_ret   <= 1'b0;
        end else if (w_lat_int) begin
            r_cause <= w_cause_int;
            r_epc   <= epc;
            r_tval  <= '0;
            r_intr  <= 1'b1;
            r_ret   <= 1'b0;
        end else if (w_lat_ret) begin
            r_ret   <= 1'b1;
        end
    end

    // Registered redirect strobes, target and busy flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_insert_pc <= 1'b0;
            r_trap_we   <= 1'b0;
            r_ret_we    <= 1'b0;
            r_priv_pc   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_insert_pc <= w_enter_redir;
            r_trap_we   <= w_enter_redir & ~r_ret;
            r_ret_we    <= w_enter_redir & r_ret;
            if (w_enter_redir) r_priv_pc <= w_tgt;
            r_busy      <= (w_next != S_IDLE);
        end
    end

    assign insert_pc = r_insert_pc;
    assign priv_pc   = r_priv_pc;
    assign intr      = r_intr;
    assign trap_we   = r_trap_we;
    assign ret_we    = r_ret_we;
    assign cause_o   = r_cause;
    assign epc_o     = r_epc;
    assign tval_o    = r_tval;
    assign busy      = r_busy;

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Scoreboard bench for priv_trap_sequencer.
// Expected redirects are queued by stimulus and checked by a strobe monitor.
module tb_priv_trap_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [8:0]  exc_req;
    logic [2:0]  prot_fault;
    logic        timer_int, soft_int, ext_int;
    logic [2:0]  mie_bits;
    logic        mstatus_mie;
    logic        ret, wfi;
    logic [31:0] epc, badaddr;
    logic        pipe_clear;
    logic [31:0] mtvec, mepc_r;
    logic        insert_pc;
    logic [31:0] priv_pc;
    logic        intr, trap_we, ret_we;
    logic [31:0] cause_o, epc_o, tval_o;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic        tw;
        logic        rw;
        logic        intr;
        logic        ci;
    } exp_t;

    exp_t q[$];

    priv_trap_sequencer #(.XLEN(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .exc_req(exc_req), .prot_fault(prot_fault),
        .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
        .mie_bits(mie_bits), .mstatus_mie(mstatus_mie),
        .ret(ret), .wfi(wfi),
        .epc(epc), .badaddr(badaddr),
        .pipe_clear(pipe_clear),
        .mtvec(mtvec), .mepc_r(mepc_r),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .intr(intr),
        .trap_we(trap_we), .ret_we(ret_we),
        .cause_o(cause_o), .epc_o(epc_o), .tval_o(tval_o),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every redirect strobe must match the oldest expectation
    always @(negedge CLK) begin
        exp_t e;
        if (nRST === 1'b1 && insert_pc === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_strobe: got insert_pc=1 pc=%h want no strobe",
                         priv_pc);
            end else begin
                e = q.pop_front();
                chk("sb_priv_pc", priv_pc, e.pc);
                chk("sb_trap_we", {31'b0, trap_we}, {31'b0, e.tw});
                chk("sb_ret_we", {31'b0, ret_we}, {31'b0, e.rw});
                chk("sb_cause", cause_o, e.cause);
                chk("sb_epc", epc_o, e.epc);
                chk("sb_tval", tval_o, e.tval);
                if (e.ci) chk("sb_intr", {31'b0, intr}, {31'b0, e.intr});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_req();
        exc_req    = '0;
        prot_fault = '0;
        timer_int  = 1'b0;
        soft_int   = 1'b0;
        ext_int    = 1'b0;
        ret        = 1'b0;
        wfi        = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] cause,
                        input logic [31:0] ep, input logic [31:0] tv,
                        input logic tw, input logic rw,
                        input logic it, input logic ci);
        exp_t e;
        e.pc = pc; e.cause = cause; e.epc = ep; e.tval = tv;
        e.tw = tw; e.rw = rw; e.intr = it; e.ci = ci;
        q.push_back(e);
    endtask

    // Request already driven; pipe_clear=1 gives DRAIN then REDIRECT
    task automatic run_seq(input string nm);
        step();
        clr_req();
        chk({nm, "_drain_busy"}, {31'b0, busy}, 32'd1);
        chk({nm, "_drain_nopc"}, {31'b0, insert_pc}, 32'd0);
        step();
        chk({nm, "_redir_pc"}, {31'b0, insert_pc}, 32'd1);
        step();
        chk({nm, "_after_pc"}, {31'b0, insert_pc}, 32'd0);
        chk({nm, "_after_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_insert"}, {31'b0, insert_pc}, 32'd0);
        chk({nm, "_priv_pc"}, priv_pc, 32'd0);
        chk({nm, "_intr"}, {31'b0, intr}, 32'd0);
        chk({nm, "_trap_we"}, {31'b0, trap_we}, 32'd0);
        chk({nm, "_ret_we"}, {31'b0, ret_we}, 32'd0);
        chk({nm, "_cause"}, cause_o, 32'd0);
        chk({nm, "_epc"}, epc_o, 32'd0);
        chk({nm, "_tval"}, tval_o, 32'd0);
        chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    logic [31:0] vec_pc;

    initial begin
`ifdef PRIV_VECTORED_INT_EN
        vec_pc = 32'h0000_012C;
`else
        vec_pc = 32'h0000_0100;
`endif
        nRST        = 1'b0;
        clr_req();
        mie_bits    = 3'b000;
        mstatus_mie = 1'b0;
        epc         = '0;
        badaddr     = '0;
        pipe_clear  = 1'b1;
        mtvec       = 32'h100;
        mepc_r      = '0;
        step();
        step();
        chk_zero("rst");
        #2 nRST = 1'b1;
        step();

        // Illegal instruction, minimum latency
        exc_req = 9'h004; epc = 32'h2000; badaddr = 32'hDEAD;
        push(32'h100, 32'd2, 32'h2000, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1);
        run_seq("illegal");
        chk("illegal_hold_cause", cause_o, 32'd2);

        // Breakpoint + mal_l with an enabled interrupt: sync wins
        exc_req = 9'h018; ext_int = 1'b1; mie_bits = 3'b100;
        mstatus_mie = 1'b1; epc = 32'h3000; badaddr = 32'h44;
        push(32'h100, 32'd3, 32'h3000, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1);
        run_seq("bp_vs_int");

        // External interrupt with vectored-mode mtvec
        ext_int = 1'b1; mtvec = 32'h101; epc = 32'h4000; badaddr = 32'h55;
        push(vec_pc, 32'h8000_000B, 32'h4000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_seq("ext_int");

        // mret: target mepc_r, latched record untouched
        ret = 1'b1; mepc_r = 32'h2004; mtvec = 32'h100;
        push(32'h2004, 32'h8000_000B, 32'h4000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_seq("mret");

        // Sync priority among load/store causes
        exc_req = 9'h0F0; epc = 32'h10; badaddr = 32'h20;
        push(32'h100, 32'd6, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        run_seq("mal_s_first");
        exc_req = 9'h140; epc = 32'h14; badaddr = 32'h24;
        push(32'h100, 32'd11, 32'h14, 32'h24, 1'b1, 1'b0, 1'b0, 1'b1);
        run_seq("env_first");
        exc_req = 9'h003; epc = 32'h18; badaddr = 32'h28;
        push(32'h100, 32'd1, 32'h18, 32'h28, 1'b1, 1'b0, 1'b0, 1'b1);
        run_seq("fault_i_first");
        prot_fault = 3'b010; epc = 32'h1C; badaddr = 32'h2C;
        push(32'h100, 32'd5, 32'h1C, 32'h2C, 1'b1, 1'b0, 1'b0, 1'b1);
        run_seq("pmp_load");

        // Interrupt priority with ext masked: soft beats timer
        ext_int = 1'b1; soft_int = 1'b1; timer_int = 1'b1;
        mie_bits = 3'b011; epc = 32'h30; badaddr = 32'h99;
        push(32'h100, 32'h8000_0003, 32'h30, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_seq("soft_int");

        // Pipeline not drained for 5 cycles; DRAIN-time requests ignored
        pipe_clear = 1'b0;
        exc_req = 9'h004; epc = 32'h2100; badaddr = 32'hBEEF;
        push(32'h100, 32'd2, 32'h2100, 32'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        exc_req = 9'h008;
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy", {31'b0, busy}, 32'd1);
            chk("stall_nopc", {31'b0, insert_pc}, 32'd0);
            step();
        end
        clr_req();
        pipe_clear = 1'b1;
        chk("stall_cause", cause_o, 32'd2);
        step();
        chk("stall_redir", {31'b0, insert_pc}, 32'd1);
        step();
        chk("stall_once", {31'b0, insert_pc}, 32'd0);

        // WFI woken by a globally disabled interrupt: no trap
        mie_bits = 3'b001; mstatus_mie = 1'b0;
        wfi = 1'b1;
        step();
        wfi = 1'b0;
        chk("wfi_sleep_busy", {31'b0, busy}, 32'd1);
        step();
        chk("wfi_still_sleep", {31'b0, busy}, 32'd1);
        timer_int = 1'b1;
        step();
        chk("wfi_wake_idle", {31'b0, busy}, 32'd0);
        chk("wfi_wake_nopc", {31'b0, insert_pc}, 32'd0);
        timer_int = 1'b0;
        step();
        chk("wfi_no_strobe", {31'b0, insert_pc}, 32'd0);

        // WFI woken by an enabled timer interrupt
        wfi = 1'b1;
        step();
        wfi = 1'b0;
        chk("wfi2_sleep_busy", {31'b0, busy}, 32'd1);
        mstatus_mie = 1'b1; timer_int = 1'b1;
        epc = 32'h5000; badaddr = 32'h66;
        push(32'h100, 32'h8000_0007, 32'h5000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_seq("wfi_timer");

        // Reset asserted during DRAIN
        pipe_clear = 1'b0;
        exc_req = 9'h004; epc = 32'h6000; badaddr = 32'h77;
        step();
        clr_req();
        chk("rstd_busy", {31'b0, busy}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk_zero("rstd");
        step();
        pipe_clear = 1'b1;
        #2 nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstd_nopc", {31'b0, insert_pc}, 32'd0);
        end

        chk("sb_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
